// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator and pixel output stage
//
// Purpose: divides clk down to a pixel tick and walks a raster of
// (H_ACTIVE+H_FP+H_SYNC+H_BP) x (V_ACTIVE+V_FP+V_SYNC+V_BP) ticks. It issues
// pixel coordinate requests to the colour source. It delays sync and blanking
// through a LATENCY-deep pipeline so that sync, blanking and colour arrive at
// the connector on the same tick.
//
// Ports:
//   clk, rst_n                  system clock, asynchronous active-low reset
//   red_in/green_in/blue_in     colour returned by the source for a requested pixel
//   cur_x, cur_y, pix_req       requested coordinate and its in-active-area flag
//   pix_tick                    one-clk pulse per pixel tick
//   line_start, frame_start     one-clk pulses coincident with request of (0,row) / (0,0)
//   h_sync, v_sync              sync to connector (asserted level = *_SYNC_POL)
//   red, green, blue            colour to DAC, zero outside the active area

module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int LATENCY    = 2,
  parameter int CW         = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    red_in,
  input  logic [3:0]    green_in,
  input  logic [3:0]    blue_in,
  output logic [CW-1:0] cur_x,
  output logic [CW-1:0] cur_y,
  output logic          pix_req,
  output logic          pix_tick,
  output logic          line_start,
  output logic          frame_start,
  output logic          h_sync,
  output logic          v_sync,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SS      = H_ACTIVE + H_FP;
  localparam int H_SE      = H_SS + H_SYNC;
  localparam int V_SS      = V_ACTIVE + V_FP;
  localparam int V_SE      = V_SS + V_SYNC;
  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  // Bit positions of the flags carried down the pipeline
  localparam int S_REQ = 2;
  localparam int S_HS  = 1;
  localparam int S_VS  = 0;

  if (CW < 1 || CW > 30 || (H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_cw_check
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
    $error("vga_timing_gen: CLK_DIV out of range 1..16");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_lat_check
    $error("vga_timing_gen: LATENCY out of range 1..4");
  end

  logic [DW-1:0]               div_cnt_q, div_cnt_d;
  logic [CW-1:0]               h_cnt_q, h_cnt_d;
  logic [CW-1:0]               v_cnt_q, v_cnt_d;
  logic [CW-1:0]               cur_x_q, cur_x_d;
  logic [CW-1:0]               cur_y_q, cur_y_d;
  logic [LATENCY-1:0][2:0]     stage_q, stage_d;
  logic                        pix_tick_q, pix_tick_d;
  logic                        line_start_q, line_start_d;
  logic                        frame_start_q, frame_start_d;
  logic                        h_sync_q, h_sync_d;
  logic                        v_sync_q, v_sync_d;
  logic [3:0]                  red_q, red_d;
  logic [3:0]                  green_q, green_d;
  logic [3:0]                  blue_q, blue_d;

  logic       tick;
  logic       h_wrap;
  logic       v_wrap;
  logic [2:0] req_flags;
  logic [2:0] fin;

  // tick marks the clk edge on which every pixel-rate register advances;
  // pix_tick is its registered copy so it lines up with the updated outputs.
  assign tick   = (div_cnt_q == DIV_LAST);
  assign h_wrap = (h_cnt_q == CW'(H_TOTAL - 1));
  assign v_wrap = (v_cnt_q == CW'(V_TOTAL - 1));

  // Region decode for the count about to be issued as a request
  assign req_flags[S_REQ] = (h_cnt_q < CW'(H_ACTIVE)) && (v_cnt_q < CW'(V_ACTIVE));
  assign req_flags[S_HS]  = (h_cnt_q >= CW'(H_SS)) && (h_cnt_q < CW'(H_SE));
  assign req_flags[S_VS]  = (v_cnt_q >= CW'(V_SS)) && (v_cnt_q < CW'(V_SE));

  // Flags of the coordinate whose colour is on red_in/green_in/blue_in now
  assign fin = stage_q[LATENCY-1];

  always_comb begin
    div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    stage_d       = stage_q;
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    pix_tick_d    = tick;
    line_start_d  = tick && (h_cnt_q == '0);
    frame_start_d = tick && (h_cnt_q == '0) && (v_cnt_q == '0);
    if (tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      end
      cur_x_d    = h_cnt_q;
      cur_y_d    = v_cnt_q;
      stage_d[0] = req_flags;
      for (int i = 1; i < LATENCY; i++) begin
        stage_d[i] = stage_q[i-1];
      end
      // Blanked pixels drive black regardless of what the source returns
      red_d    = fin[S_REQ] ? red_in   : 4'h0;
      green_d  = fin[S_REQ] ? green_in : 4'h0;
      blue_d   = fin[S_REQ] ? blue_in  : 4'h0;
      h_sync_d = fin[S_HS] ? H_SYNC_POL : ~H_SYNC_POL;
      v_sync_d = fin[S_VS] ? V_SYNC_POL : ~V_SYNC_POL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      stage_q       <= '0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      h_sync_q      <= ~H_SYNC_POL;
      v_sync_q      <= ~V_SYNC_POL;
      red_q         <= 4'h0;
      green_q       <= 4'h0;
      blue_q        <= 4'h0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      stage_q       <= stage_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
    end
  end

  assign cur_x       = cur_x_q;
  assign cur_y       = cur_y_q;
  assign pix_req     = stage_q[0][S_REQ];
  assign pix_tick    = pix_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
//
// Three instances: u0 default timing, u1 small fast raster (CLK_DIV=1,
// LATENCY=1, positive sync), u2 small raster with LATENCY=4.

module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic rst_n0, rst_n1, rst_n2;

  logic [11:0] cur_x0, cur_y0, cur_x1, cur_y1, cur_x2, cur_y2;
  logic pix_req0, pix_tick0, line_start0, frame_start0, h_sync0, v_sync0;
  logic pix_req1, pix_tick1, line_start1, frame_start1, h_sync1, v_sync1;
  logic pix_req2, pix_tick2, line_start2, frame_start2, h_sync2, v_sync2;
  logic [3:0] red0, green0, blue0, red1, green1, blue1, red2, green2, blue2;
  logic [3:0] src0;

  // Colour source for u0 with one tick of latency: it registers cur_x on each
  // tick boundary (with CLK_DIV=2 those are the edges after a pix_tick-low cycle).
  always @(posedge clk) begin
    if (!pix_tick0) src0 <= cur_x0[3:0];
  end

  vga_timing_gen u0 (
    .clk(clk), .rst_n(rst_n0),
    .red_in(src0), .green_in(4'h5), .blue_in(4'hA),
    .cur_x(cur_x0), .cur_y(cur_y0), .pix_req(pix_req0), .pix_tick(pix_tick0),
    .line_start(line_start0), .frame_start(frame_start0),
    .h_sync(h_sync0), .v_sync(v_sync0), .red(red0), .green(green0), .blue(blue0)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .LATENCY(1), .CW(12)
  ) u1 (
    .clk(clk), .rst_n(rst_n1),
    .red_in(4'hF), .green_in(4'h3), .blue_in(4'h9),
    .cur_x(cur_x1), .cur_y(cur_y1), .pix_req(pix_req1), .pix_tick(pix_tick1),
    .line_start(line_start1), .frame_start(frame_start1),
    .h_sync(h_sync1), .v_sync(v_sync1), .red(red1), .green(green1), .blue(blue1)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .LATENCY(4), .CW(12)
  ) u2 (
    .clk(clk), .rst_n(rst_n2),
    .red_in(4'hC), .green_in(4'h6), .blue_in(4'h1),
    .cur_x(cur_x2), .cur_y(cur_y2), .pix_req(pix_req2), .pix_tick(pix_tick2),
    .line_start(line_start2), .frame_start(frame_start2),
    .h_sync(h_sync2), .v_sync(v_sync2), .red(red2), .green(green2), .blue(blue2)
  );

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cur_x0, cur_y0, pix_req0, pix_tick0, line_start0, frame_start0} !== 28'h0) begin
      failures++;
      $display("FAIL reset_u0_ctrl got=%h exp=0", {cur_x0, cur_y0, pix_req0, pix_tick0, line_start0, frame_start0});
    end
    checks++;
    if ({h_sync0, v_sync0, red0, green0, blue0} !== {2'b11, 12'h000}) begin
      failures++;
      $display("FAIL reset_u0_pins got=%h exp=%h", {h_sync0, v_sync0, red0, green0, blue0}, {2'b11, 12'h000});
    end
    checks++;
    if ({pix_tick1, frame_start1, pix_req1, h_sync1, v_sync1, red1, green1, blue1} !== 17'h0) begin
      failures++;
      $display("FAIL reset_u1 got=%h exp=0", {pix_tick1, frame_start1, pix_req1, h_sync1, v_sync1, red1, green1, blue1});
    end
    checks++;
    if ({pix_tick2, pix_req2, h_sync2, v_sync2, red2} !== {2'b00, 2'b11, 4'h0}) begin
      failures++;
      $display("FAIL reset_u2 got=%b exp=%b", {pix_tick2, pix_req2, h_sync2, v_sync2, red2}, {2'b00, 2'b11, 4'h0});
    end
  endtask

  task automatic test_default_raster();
    int k, c, xc, yc, hs_low, ls_first, ls_second;
    logic [3:0]  e_ctrl;
    logic [11:0] e_x, e_y, e_rgb;
    logic [1:0]  e_sync;
    hs_low = 0; ls_first = -1; ls_second = -1;
    @(negedge clk);
    rst_n0 = 1'b1;
    for (int j = 1; j <= 1700; j++) begin
      @(negedge clk);
      e_ctrl = 4'b0000; e_x = 12'h0; e_y = 12'h0; e_sync = 2'b11; e_rgb = 12'h0;
      if (j >= 2) begin
        k = (j - 2) / 2;
        xc = k % 800; yc = (k / 800) % 525;
        e_x = 12'(xc); e_y = 12'(yc);
        // {pix_tick, frame_start, line_start, pix_req}
        e_ctrl = {(j % 2 == 0), (j % 2 == 0) && xc == 0 && yc == 0,
                  (j % 2 == 0) && xc == 0, xc < 640 && yc < 480};
        if (k >= 2) begin
          c = k - 2; xc = c % 800; yc = c / 800;
          e_sync = {!(xc >= 656 && xc < 752), !(yc >= 490 && yc < 492)};
          if (xc < 640 && yc < 480) e_rgb = {4'(xc), 4'h5, 4'hA};
        end
      end
      checks++;
      if ({pix_tick0, frame_start0, line_start0, pix_req0} !== e_ctrl) begin
        failures++;
        $display("FAIL u0_ctrl j=%0d got=%b exp=%b", j, {pix_tick0, frame_start0, line_start0, pix_req0}, e_ctrl);
      end
      checks++;
      if (cur_x0 !== e_x || cur_y0 !== e_y) begin
        failures++;
        $display("FAIL u0_coord j=%0d got=(%0d,%0d) exp=(%0d,%0d)", j, cur_x0, cur_y0, e_x, e_y);
      end
      checks++;
      if ({h_sync0, v_sync0} !== e_sync) begin
        failures++;
        $display("FAIL u0_sync j=%0d got=%b exp=%b", j, {h_sync0, v_sync0}, e_sync);
      end
      checks++;
      if ({red0, green0, blue0} !== e_rgb) begin
        failures++;
        $display("FAIL u0_rgb j=%0d got=%h exp=%h", j, {red0, green0, blue0}, e_rgb);
      end
      if (h_sync0 === 1'b0) hs_low++;
      if (line_start0 === 1'b1) begin
        if (ls_first < 0) ls_first = j;
        else if (ls_second < 0) ls_second = j;
      end
    end
    checks++;
    if (hs_low != 192) begin
      failures++;
      $display("FAIL u0_hsync_width got=%0d clk exp=192 clk", hs_low);
    end
    checks++;
    if (ls_first != 2 || ls_second - ls_first != 1600) begin
      failures++;
      $display("FAIL u0_line_period got first=%0d period=%0d exp first=2 period=1600", ls_first, ls_second - ls_first);
    end
  endtask

  task automatic test_midline_reset();
    int n;
    n = 0;
    while (n < 1200 && !(cur_x0 === 12'd300 && cur_y0 === 12'd1)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cur_x0 !== 12'd300 || cur_y0 !== 12'd1) begin
      failures++;
      $display("FAIL mid_reset_reach got=(%0d,%0d) exp=(300,1)", cur_x0, cur_y0);
    end
    #2 rst_n0 = 1'b0;
    #1;
    checks++;
    if ({cur_x0, cur_y0, pix_req0, pix_tick0, line_start0, frame_start0} !== 28'h0) begin
      failures++;
      $display("FAIL mid_reset_ctrl got=%h exp=0", {cur_x0, cur_y0, pix_req0, pix_tick0, line_start0, frame_start0});
    end
    checks++;
    if ({h_sync0, v_sync0, red0, green0, blue0} !== {2'b11, 12'h000}) begin
      failures++;
      $display("FAIL mid_reset_pins got=%h exp=%h", {h_sync0, v_sync0, red0, green0, blue0}, {2'b11, 12'h000});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({frame_start0, pix_tick0} !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset_clk1 got=%b exp=00", {frame_start0, pix_tick0});
    end
    @(negedge clk);
    checks++;
    if ({frame_start0, pix_tick0, pix_req0} !== 3'b111 || cur_x0 !== 12'd0 || cur_y0 !== 12'd0) begin
      failures++;
      $display("FAIL mid_reset_restart got fs/pt/req=%b xy=(%0d,%0d) exp 111 (0,0)", {frame_start0, pix_tick0, pix_req0}, cur_x0, cur_y0);
    end
  endtask

  task automatic test_fast_small();
    int k, c, xc, yc, fs_first, fs_second, vs_high, hs_high;
    logic [3:0]  e_ctrl;
    logic [11:0] e_rgb;
    logic [1:0]  e_sync;
    fs_first = -1; fs_second = -1; vs_high = 0; hs_high = 0;
    @(negedge clk);
    rst_n1 = 1'b1;
    for (int j = 1; j <= 201; j++) begin
      @(negedge clk);
      k = j - 1;
      xc = k % 14; yc = (k / 14) % 7;
      e_ctrl = {1'b1, xc == 0 && yc == 0, xc == 0, xc < 8 && yc < 4};
      e_sync = 2'b00; e_rgb = 12'h0;
      if (k >= 1) begin
        c = k - 1; xc = c % 14; yc = (c / 14) % 7;
        e_sync = {xc >= 10 && xc < 12, yc == 5};
        if (xc < 8 && yc < 4) e_rgb = 12'hF39;
      end
      checks++;
      if ({pix_tick1, frame_start1, line_start1, pix_req1} !== e_ctrl || cur_x1 !== 12'(k % 14) || cur_y1 !== 12'((k / 14) % 7)) begin
        failures++;
        $display("FAIL u1_ctrl j=%0d got=%b (%0d,%0d) exp=%b (%0d,%0d)", j, {pix_tick1, frame_start1, line_start1, pix_req1}, cur_x1, cur_y1, e_ctrl, k % 14, (k / 14) % 7);
      end
      checks++;
      if ({h_sync1, v_sync1} !== e_sync || {red1, green1, blue1} !== e_rgb) begin
        failures++;
        $display("FAIL u1_pins j=%0d got sync=%b rgb=%h exp sync=%b rgb=%h", j, {h_sync1, v_sync1}, {red1, green1, blue1}, e_sync, e_rgb);
      end
      if (frame_start1 === 1'b1) begin
        if (fs_first < 0) fs_first = j;
        else if (fs_second < 0) fs_second = j;
      end
      if (j <= 98 && v_sync1 === 1'b1) vs_high++;
      if (j <= 14 && h_sync1 === 1'b1) hs_high++;
    end
    checks++;
    if (fs_first != 1 || fs_second - fs_first != 98) begin
      failures++;
      $display("FAIL u1_frame_period got first=%0d period=%0d exp first=1 period=98", fs_first, fs_second - fs_first);
    end
    checks++;
    if (vs_high != 14 || hs_high != 2) begin
      failures++;
      $display("FAIL u1_sync_widths got v=%0d h=%0d exp v=14 h=2", vs_high, hs_high);
    end
  endtask

  task automatic test_latency4();
    int k, c, xc, yc;
    int first_req, first_red, first_x10, first_hs_low, first_y5, first_vs_low;
    logic [11:0] e_rgb;
    logic [1:0]  e_sync;
    first_req = -1; first_red = -1; first_x10 = -1;
    first_hs_low = -1; first_y5 = -1; first_vs_low = -1;
    @(negedge clk);
    rst_n2 = 1'b1;
    for (int j = 1; j <= 216; j++) begin
      @(negedge clk);
      e_sync = 2'b11; e_rgb = 12'h0;
      k = (j >= 2) ? (j - 2) / 2 : 0;
      if (j >= 2 && k >= 4) begin
        c = k - 4; xc = c % 14; yc = (c / 14) % 7;
        e_sync = {!(xc >= 10 && xc < 12), !(yc == 5)};
        if (xc < 8 && yc < 4) e_rgb = 12'hC61;
      end
      checks++;
      if (cur_x2 !== 12'((j >= 2) ? k % 14 : 0) || cur_y2 !== 12'((j >= 2) ? (k / 14) % 7 : 0)) begin
        failures++;
        $display("FAIL u2_coord j=%0d got=(%0d,%0d)", j, cur_x2, cur_y2);
      end
      checks++;
      if ({h_sync2, v_sync2} !== e_sync || {red2, green2, blue2} !== e_rgb) begin
        failures++;
        $display("FAIL u2_pins j=%0d got sync=%b rgb=%h exp sync=%b rgb=%h", j, {h_sync2, v_sync2}, {red2, green2, blue2}, e_sync, e_rgb);
      end
      if (first_req < 0 && pix_req2 === 1'b1) first_req = j;
      if (first_red < 0 && red2 === 4'hC) first_red = j;
      if (first_x10 < 0 && cur_x2 === 12'd10) first_x10 = j;
      if (first_hs_low < 0 && h_sync2 === 1'b0) first_hs_low = j;
      if (first_y5 < 0 && cur_y2 === 12'd5 && cur_x2 === 12'd0) first_y5 = j;
      if (first_vs_low < 0 && v_sync2 === 1'b0) first_vs_low = j;
    end
    checks++;
    if (first_req != 2 || first_red - first_req != 8) begin
      failures++;
      $display("FAIL u2_colour_lag got req=%0d lag=%0d clk exp req=2 lag=8 clk", first_req, first_red - first_req);
    end
    checks++;
    if (first_x10 < 0 || first_hs_low - first_x10 != 8) begin
      failures++;
      $display("FAIL u2_hsync_lag got=%0d clk exp=8 clk", first_hs_low - first_x10);
    end
    checks++;
    if (first_y5 != 142 || first_vs_low - first_y5 != 8) begin
      failures++;
      $display("FAIL u2_vsync_lag got y5=%0d lag=%0d exp y5=142 lag=8", first_y5, first_vs_low - first_y5);
    end
  endtask

  initial begin
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    rst_n2 = 1'b0;
    test_reset();
    test_default_raster();
    test_midline_reset();
    test_fast_small();
    test_latency4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
